// File: rtl/addr_mult_issue_if.sv
// Issue/writeback bundle between the A-register issue stage and its surroundings.
// Signal names carry the direction as seen from the issue stage (slave side).
interface addr_mult_issue_if #(
    parameter int WIDTH = 24,
    parameter int NREGS = 8,
    parameter int AW    = 3
);
    logic             i_issue_valid;
    logic             o_issue_ready;
    logic [AW-1:0]    i_src_j;
    logic [AW-1:0]    i_src_k;
    logic [AW-1:0]    i_dst;
    logic [WIDTH-1:0] i_aj;
    logic [WIDTH-1:0] i_ak;
    logic [WIDTH-1:0] o_aj;
    logic [WIDTH-1:0] o_ak;
    logic [WIDTH-1:0] i_mult_result;
    logic             o_wb_en;
    logic [AW-1:0]    o_wb_addr;
    logic [WIDTH-1:0] o_wb_data;
    logic [NREGS-1:0] o_resv;

    modport slave (
        input  i_issue_valid, i_src_j, i_src_k, i_dst, i_aj, i_ak, i_mult_result,
        output o_issue_ready, o_aj, o_ak, o_wb_en, o_wb_addr, o_wb_data, o_resv
    );

    modport master (
        output i_issue_valid, i_src_j, i_src_k, i_dst, i_aj, i_ak, i_mult_result,
        input  o_issue_ready, o_aj, o_ak, o_wb_en, o_wb_addr, o_wb_data, o_resv
    );
endinterface

// File: rtl/addr_mult_issue.sv
// Issue/writeback control around a fully pipelined address multiplier:
// reservation check, operand bypass, latency-matched tag pipe and reservation release.
module addr_mult_issue #(
    parameter int WIDTH        = 24,
    parameter int NREGS        = 8,
    parameter int AW           = 3,
    parameter int MULT_LATENCY = 6
) (
    input  logic            clk,
    input  logic            rst,
    addr_mult_issue_if.slave bus
);
    // The operand register is the first tag stage; the multiplier adds MULT_LATENCY more.
    localparam int NSTG = MULT_LATENCY + 1;

    logic [NREGS-1:0] r_resv;
    logic [NREGS-1:0] w_resv_nxt;
    logic [NSTG-1:0]  r_tag_vld;
    logic [AW-1:0]    r_tag_dst [NSTG];
    logic [WIDTH-1:0] r_aj;
    logic [WIDTH-1:0] r_ak;

    logic          w_wb_en;
    logic [AW-1:0] w_wb_addr;
    logic          w_byp_j;
    logic          w_byp_k;
    logic          w_hz_j;
    logic          w_hz_k;
    logic          w_hz_d;
    logic          w_ready;
    logic          w_accept;

    assign w_wb_en   = r_tag_vld[NSTG-1];
    assign w_wb_addr = r_tag_dst[NSTG-1];

    // A source being written back this cycle is taken from the multiplier output.
    assign w_byp_j = w_wb_en && (w_wb_addr == bus.i_src_j);
    assign w_byp_k = w_wb_en && (w_wb_addr == bus.i_src_k);

    assign w_hz_j   = r_resv[bus.i_src_j] && !w_byp_j;
    assign w_hz_k   = r_resv[bus.i_src_k] && !w_byp_k;
    assign w_hz_d   = r_resv[bus.i_dst];
    assign w_ready  = !w_hz_j && !w_hz_k && !w_hz_d;
    assign w_accept = bus.i_issue_valid && w_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_aj <= '0;
            r_ak <= '0;
        end else if (w_accept) begin
            r_aj <= w_byp_j ? bus.i_mult_result : bus.i_aj;
            r_ak <= w_byp_k ? bus.i_mult_result : bus.i_ak;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tag_vld <= '0;
            for (int i = 0; i < NSTG; i++) begin
                r_tag_dst[i] <= '0;
            end
        end else begin
            r_tag_vld    <= {r_tag_vld[NSTG-2:0], w_accept};
            r_tag_dst[0] <= bus.i_dst;
            for (int i = 1; i < NSTG; i++) begin
                r_tag_dst[i] <= r_tag_dst[i-1];
            end
        end
    end

    // Release before set so a same-index set in the same edge wins.
    always_comb begin
        w_resv_nxt = r_resv;
        if (w_wb_en) begin
            w_resv_nxt[w_wb_addr] = 1'b0;
        end
        if (w_accept) begin
            w_resv_nxt[bus.i_dst] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_resv <= '0;
        end else begin
            r_resv <= w_resv_nxt;
        end
    end

    assign bus.o_issue_ready = w_ready;
    assign bus.o_aj          = r_aj;
    assign bus.o_ak          = r_ak;
    assign bus.o_wb_en       = w_wb_en;
    assign bus.o_wb_addr     = w_wb_addr;
    assign bus.o_wb_data     = bus.i_mult_result;
    assign bus.o_resv        = r_resv;
endmodule

// File: tb/tb_addr_mult_issue.sv
// Bench for addr_mult_issue: behavioural 6-stage multiplier, scoreboard of expected
// writebacks, a vector table for independent issues and hand sequences for hazards.
module tb_addr_mult_issue;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    addr_mult_issue_if #(.WIDTH(24), .NREGS(8), .AW(3)) bus ();

    addr_mult_issue #(.WIDTH(24), .NREGS(8), .AW(3), .MULT_LATENCY(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Multiplier model: captures registered operands, product appears 6 edges later.
    logic [23:0] mp [6];
    logic [47:0] w_full;
    assign w_full = bus.o_aj * bus.o_ak;
    always @(posedge clk) begin
        mp[0] <= w_full[23:0];
        for (int i = 1; i < 6; i++) mp[i] <= mp[i-1];
    end
    assign bus.i_mult_result = mp[5];

    typedef struct {
        logic [2:0]  dst;
        logic [23:0] data;
        logic [63:0] t;
    } sb_t;
    sb_t sb [$];

    typedef struct {
        logic [2:0]  dst;
        logic [2:0]  j;
        logic [2:0]  k;
        logic [23:0] aj;
        logic [23:0] ak;
        logic [23:0] prod;
    } vec_t;
    vec_t vt [8];

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Writeback must land 6 edges after the accept edge, observed on the next negedge.
    always @(negedge clk) begin
        if (!rst && bus.o_wb_en) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL wb_unexpected: got wb_en=1 addr=%0d expected no writeback at %0t",
                         bus.o_wb_addr, $time);
            end else begin
                sb_t e;
                e = sb.pop_front();
                chk("wb_addr", 64'(bus.o_wb_addr), 64'(e.dst));
                chk("wb_data", 64'(bus.o_wb_data), 64'(e.data));
                chk("wb_time", $time, e.t + 64'd65);
            end
        end
    end

    task automatic drive(input logic [2:0] dst, input logic [2:0] j, input logic [2:0] k,
                         input logic [23:0] aj, input logic [23:0] ak);
        bus.i_issue_valid = 1'b1;
        bus.i_dst   = dst;
        bus.i_src_j = j;
        bus.i_src_k = k;
        bus.i_aj    = aj;
        bus.i_ak    = ak;
    endtask

    task automatic idle();
        bus.i_issue_valid = 1'b0;
        bus.i_src_j = 3'd0;
        bus.i_src_k = 3'd7;
        bus.i_dst   = 3'd7;
    endtask

    // Called just after a negedge with inputs driven; returns at the following negedge.
    task automatic step_issue(input string nm, input bit exp_rdy,
                              input logic [23:0] ea, input logic [23:0] eb, input logic [23:0] ep);
        logic r;
        #1;
        r = bus.o_issue_ready;
        chk({nm, "_ready"}, 64'(r), 64'(exp_rdy));
        @(posedge clk);
        if (r) sb.push_back('{bus.i_dst, ep, $time});
        #1;
        if (r) begin
            chk({nm, "_aj"}, 64'(bus.o_aj), 64'(ea));
            chk({nm, "_ak"}, 64'(bus.o_ak), 64'(eb));
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{3'd1, 3'd0, 3'd7, 24'h000010, 24'h000003, 24'h000030};
        vt[1] = '{3'd2, 3'd0, 3'd7, 24'h000100, 24'h000100, 24'h010000};
        vt[2] = '{3'd3, 3'd0, 3'd7, 24'h001000, 24'h001000, 24'h000000};
        vt[3] = '{3'd4, 3'd0, 3'd7, 24'h000007, 24'h000009, 24'h00003F};
        vt[4] = '{3'd5, 3'd0, 3'd7, 24'h123456, 24'h000001, 24'h123456};
        vt[5] = '{3'd6, 3'd0, 3'd7, 24'h000ABC, 24'h000010, 24'h00ABC0};
        vt[6] = '{3'd3, 3'd0, 3'd7, 24'hFFFFFF, 24'h000002, 24'hFFFFFE};
        vt[7] = '{3'd7, 3'd0, 3'd6, 24'hFFFFFF, 24'hFFFFFF, 24'h000001};

        rst = 1'b1;
        idle();
        bus.i_aj = '0;
        bus.i_ak = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_wb_en",   64'(bus.o_wb_en),       64'd0);
        chk("rst_wb_addr", 64'(bus.o_wb_addr),     64'd0);
        chk("rst_aj",      64'(bus.o_aj),          64'd0);
        chk("rst_ak",      64'(bus.o_ak),          64'd0);
        chk("rst_resv",    64'(bus.o_resv),        64'd0);
        chk("rst_ready",   64'(bus.o_issue_ready), 64'd1);
        @(negedge clk);

        // Single issue A1 = A2*A3 and reservation lifetime.
        drive(3'd1, 3'd2, 3'd3, 24'd3, 24'd5);
        step_issue("t1", 1'b1, 24'd3, 24'd5, 24'd15);
        idle();
        chk("t1_resv_set", 64'(bus.o_resv), 64'h02);
        repeat (6) @(negedge clk);
        chk("t1_wb_cycle", 64'(bus.o_wb_en), 64'd1);
        chk("t1_resv_wb",  64'(bus.o_resv),  64'h02);
        @(negedge clk);
        chk("t1_wb_done",  64'(bus.o_wb_en), 64'd0);
        chk("t1_resv_clr", 64'(bus.o_resv),  64'h00);
        repeat (2) @(negedge clk);

        // RAW on A1: blocked until A1's writeback cycle, then issued with bypassed operand.
        drive(3'd1, 3'd2, 3'd3, 24'd3, 24'd5);
        step_issue("t2a", 1'b1, 24'd3, 24'd5, 24'd15);
        drive(3'd4, 3'd1, 3'd2, 24'h000777, 24'd4);
        for (int i = 0; i < 7; i++) step_issue("t2b", (i == 6), 24'd15, 24'd4, 24'd60);
        idle();
        repeat (9) @(negedge clk);

        // Six independent back-to-back issues, then WAW on A1.
        for (int i = 0; i < 6; i++) begin
            drive(vt[i].dst, vt[i].j, vt[i].k, vt[i].aj, vt[i].ak);
            step_issue("t3", 1'b1, vt[i].aj, vt[i].ak, vt[i].prod);
        end
        drive(3'd1, 3'd0, 3'd7, 24'd9, 24'd9);
        for (int i = 0; i < 3; i++) step_issue("t3_waw", (i == 2), 24'd9, 24'd9, 24'd81);
        idle();
        repeat (9) @(negedge clk);

        // Truncating products.
        for (int i = 6; i < 8; i++) begin
            drive(vt[i].dst, vt[i].j, vt[i].k, vt[i].aj, vt[i].ak);
            step_issue("t4", 1'b1, vt[i].aj, vt[i].ak, vt[i].prod);
        end
        idle();
        repeat (9) @(negedge clk);
        chk("t4_resv", 64'(bus.o_resv), 64'h00);

        // Reset with three operations in flight.
        for (int i = 0; i < 3; i++) begin
            drive(vt[i].dst, vt[i].j, vt[i].k, vt[i].aj, vt[i].ak);
            step_issue("t5", 1'b1, vt[i].aj, vt[i].ak, vt[i].prod);
        end
        idle();
        #2;
        rst = 1'b1;
        sb.delete();
        #1;
        chk("t5_resv_rst",  64'(bus.o_resv),  64'h00);
        chk("t5_wb_en_rst", 64'(bus.o_wb_en), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("t5_ready", 64'(bus.o_issue_ready), 64'd1);
        repeat (8) @(negedge clk);
        drive(vt[7].dst, vt[7].j, vt[7].k, vt[7].aj, vt[7].ak);
        step_issue("t5_new", 1'b1, vt[7].aj, vt[7].ak, vt[7].prod);
        idle();
        repeat (9) @(negedge clk);

        // WAW to A2 presented through A2's writeback cycle; accepted the cycle after.
        drive(3'd2, 3'd0, 3'd7, 24'd2, 24'h21);
        step_issue("t6a", 1'b1, 24'd2, 24'h21, 24'h42);
        drive(3'd2, 3'd0, 3'd7, 24'd5, 24'd6);
        for (int i = 0; i < 8; i++) step_issue("t6b", (i == 7), 24'd5, 24'd6, 24'h1E);
        idle();
        chk("t6_resv", 64'(bus.o_resv), 64'h04);
        repeat (9) @(negedge clk);
        chk("t6_resv_end", 64'(bus.o_resv), 64'h00);

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
